uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, line rate in bits/s; ONE_BIT_CNT = CLK_FREQUENCY/BAUD_RATE (integer division).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte entries; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port din, input, 8, byte to enqueue.
REQ-007 SHALL have port wr_en, input, 1, enqueue request, sampled each edge.
REQ-008 SHALL have port odd, input, 1, parity select: 1 = odd parity, 0 = even parity.
REQ-009 SHALL have port tx_out, output, 1, registered serial line, idle high.
REQ-010 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port empty, output, 1, FIFO holds 0 entries.
REQ-012 SHALL have port busy, output, 1, a frame is in progress on tx_out.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on the final cycle of each stop bit.

Function
REQ-014 Frame SHALL be 11 bits: start (0), din[0]..din[7] LSB first, parity, stop (1).
REQ-015 Parity bit SHALL equal (^byte) ^ odd, with odd latched at frame load; odd changes mid-frame SHALL have no effect on that frame.
REQ-016 Every bit SHALL hold on tx_out exactly ONE_BIT_CNT clk cycles; frame length = 11*ONE_BIT_CNT cycles.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; bit counter 0..7 in DATA; cycle timer 0..ONE_BIT_CNT-1 in all non-IDLE states.
REQ-018 Transitions: IDLE->START when !empty (pop + load shift register same edge); START->DATA, DATA(bit 7)->PARITY, PARITY->STOP on timer terminal count.
REQ-019 STOP on terminal count: ->START with pop if !empty (no idle gap between frames), else ->IDLE.
REQ-020 Write into empty FIFO on edge N SHALL make tx_out fall on edge N+2.
REQ-021 Write SHALL be accepted iff wr_en && !full in that cycle; writes while full SHALL be dropped silently with no state change.
REQ-022 Simultaneous accepted write and pop SHALL leave occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 full/empty SHALL be registered-state flags valid the cycle after the causing edge.
REQ-024 busy SHALL be 1 in START/DATA/PARITY/STOP, 0 in IDLE; tx_out SHALL be 1 in IDLE.
REQ-025 done SHALL assert exactly once per frame, never in IDLE or on reset.

Reset
REQ-026 rst SHALL, on the next edge, set tx_out=1, busy=0, done=0, empty=1, full=0, FSM=IDLE, timer and bit counter 0, pointers 0.
REQ-027 rst mid-frame SHALL abandon the frame and discard all queued bytes; wr_en during rst SHALL be ignored.

Verification (CLK_FREQUENCY=1000, BAUD_RATE=100, ONE_BIT_CNT=10)
REQ-028 Write din=0x55, odd=0 -> tx_out bits 0,1,0,1,0,1,0,1,0,0(parity),1(stop), 10 cycles each; done pulse at cycle 110 of frame; then busy=0.
REQ-029 Write din=0x07, odd=1 -> data 1,1,1,0,0,0,0,0; parity=0; stop=1.
REQ-030 Write 6 bytes on consecutive edges from empty -> full=1 after 5th write, 6th dropped; 5 contiguous frames (550 cycles) with no high gap between stop and next start; 5 done pulses.
REQ-031 Assert rst for one cycle at cycle 40 of a frame with 2 bytes queued -> next cycle tx_out=1, busy=0, empty=1; no further frames, no done.
REQ-032 No writes for 200 cycles after reset -> tx_out=1, busy=0, done=0 throughout.
REQ-033 Toggle odd every cycle during a 0x00 frame latched with odd=1 -> parity bit =1 for full 10 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Frame: start, 8 data bits LSB first, parity, stop.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       wr_en,
    input  logic       odd,
    output logic       tx_out,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       done
);

    localparam int ONE_BIT_CNT = CLK_FREQUENCY / BAUD_RATE;
    localparam int TW = (ONE_BIT_CNT > 1) ? $clog2(ONE_BIT_CNT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(ONE_BIT_CNT - 1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [AW:0]   cnt_nxt;
    logic [7:0]    head;

    logic tc;
    logic push;
    logic pop;

    assign tc   = (timer == T_LAST);
    assign push = wr_en && !full;
    assign pop  = !empty &&
                  ((state == IDLE) || ((state == STOP) && tc));
    assign head = mem[rptr];

    // Next occupancy: a push and a pop together cancel out.
    always_comb begin
        cnt_nxt = count;
        unique case ({push, pop})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    // Byte storage; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CNT_FULL);
        end
    end

    // Frame sequencer; line outputs are registered from the current
    // state, so the line trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done  <= (state == STOP) && tc;
            busy  <= (state != IDLE);
            timer <= ((state == IDLE) || tc) ? '0 : timer + 1'b1;
            unique case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (pop) begin
                        shreg <= head;
                        par   <= (^head) ^ odd;
                        state <= START;
                    end
                end
                START: begin
                    tx_out <= 1'b0;
                    if (tc) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx_out <= shreg[0];
                    if (tc) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    tx_out <= par;
                    if (tc) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    tx_out <= 1'b1;
                    if (tc) begin
                        if (pop) begin
                            shreg <= head;
                            par   <= (^head) ^ odd;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_out <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit.
// Frames are checked bit by bit on the falling clock edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       odd;
    logic       tx_out;
    logic       full;
    logic       empty;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .CLK_FREQUENCY(1000),
        .BAUD_RATE    (100),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .wr_en (wr_en),
        .odd   (odd),
        .tx_out(tx_out),
        .full  (full),
        .empty (empty),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        o;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        din   = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic quiet(input string nm, input int n);
        int viol = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
                viol++;
            @(negedge clk);
        end
        chk(nm, viol, 0);
    endtask

    // exp[0] is the start bit, exp[10] the stop bit.
    task automatic check_frame(input string nm, input logic [10:0] exp,
                               input int max_wait, input bit tog,
                               output int lat);
        int bad[11];
        int busy_bad = 0;
        int dn_cnt   = 0;
        int dn_pos   = -1;
        lat = 0;
        while (tx_out !== 1'b0 && lat < max_wait) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " start seen"}, {31'd0, tx_out}, 0);
        if (tx_out !== 1'b0) return;
        for (int b = 0; b < 11; b++) bad[b] = 0;
        for (int k = 0; k < 110; k++) begin
            if (tx_out !== exp[k/10]) bad[k/10]++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                dn_cnt++;
                dn_pos = k;
            end
            if (tog) odd = ~odd;
            @(negedge clk);
        end
        for (int b = 0; b < 11; b++)
            chk($sformatf("%s bit%0d errs", nm, b), bad[b], 0);
        chk({nm, " busy low in frame"}, busy_bad, 0);
        chk({nm, " done count"}, dn_cnt, 1);
        chk({nm, " done position"}, dn_pos, 109);
    endtask

    initial begin
        int lat;
        logic [7:0]  seq_d [6];
        logic [10:0] seq_f [5];

        vecs[0] = '{8'h55, 1'b0, 11'b1_0_01010101_0};
        vecs[1] = '{8'h07, 1'b1, 11'b1_0_00000111_0};
        vecs[2] = '{8'hA3, 1'b0, 11'b1_0_10100011_0};
        vecs[3] = '{8'hFF, 1'b1, 11'b1_1_11111111_0};
        vecs[4] = '{8'h00, 1'b0, 11'b1_0_00000000_0};
        vecs[5] = '{8'h80, 1'b0, 11'b1_1_10000000_0};

        seq_d = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
        seq_f[0] = 11'b1_1_00000001_0;
        seq_f[1] = 11'b1_0_00000011_0;
        seq_f[2] = 11'b1_1_00000111_0;
        seq_f[3] = 11'b1_0_00001111_0;
        seq_f[4] = 11'b1_1_00011111_0;

        rst   = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;
        odd   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset tx_out", {31'd0, tx_out}, 1);
        chk("reset busy",   {31'd0, busy},   0);
        chk("reset done",   {31'd0, done},   0);
        chk("reset empty",  {31'd0, empty},  1);
        chk("reset full",   {31'd0, full},   0);

        quiet("idle 200 cycles", 200);

        for (int i = 0; i < 6; i++) begin
            odd = vecs[i].o;
            put(vecs[i].d);
            chk($sformatf("vec%0d empty after write", i),
                {31'd0, empty}, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].frame, 20, 1'b0, lat);
            chk($sformatf("vec%0d latency", i), lat, 2);
            chk($sformatf("vec%0d busy after", i), {31'd0, busy}, 0);
            chk($sformatf("vec%0d idle line", i), {31'd0, tx_out}, 1);
        end

        odd = 1'b1;
        put(8'h00);
        check_frame("odd toggle", 11'b1_1_00000000_0, 20, 1'b1, lat);
        odd = 1'b0;
        quiet("after toggle", 5);

        fork
            begin
                wr_en = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    din = seq_d[i];
                    if (i == 4) chk("full after 4 writes", {31'd0, full}, 0);
                    if (i == 5) chk("full after 5 writes", {31'd0, full}, 1);
                    @(negedge clk);
                end
                wr_en = 1'b0;
                chk("full after drop", {31'd0, full}, 1);
            end
            begin
                check_frame("burst0", seq_f[0], 20, 1'b0, lat);
                for (int i = 1; i < 5; i++)
                    check_frame($sformatf("burst%0d", i), seq_f[i], 0,
                                1'b0, lat);
            end
        join
        chk("burst busy after", {31'd0, busy},  0);
        chk("burst empty after", {31'd0, empty}, 1);
        quiet("no sixth frame", 40);

        put(8'hAA);
        put(8'hBB);
        put(8'hCC);
        lat = 0;
        while (tx_out !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rst test start seen", {31'd0, tx_out}, 0);
        repeat (39) @(negedge clk);
        chk("rst test queue", {31'd0, empty}, 0);
        rst   = 1'b1;
        wr_en = 1'b1;
        din   = 8'h5A;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        chk("mid rst tx_out", {31'd0, tx_out}, 1);
        chk("mid rst busy",   {31'd0, busy},   0);
        chk("mid rst empty",  {31'd0, empty},  1);
        chk("mid rst full",   {31'd0, full},   0);
        chk("mid rst done",   {31'd0, done},   0);
        quiet("after mid rst", 300);
        chk("after mid rst empty", {31'd0, empty}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
